// File: rtl/tournament_pkg.sv
// Shared types for the tournament predictor: history width,
// history type and the in-flight prediction record.
package tournament_pkg;

  localparam int TP_HIST_W = 12;

  typedef logic [TP_HIST_W-1:0] hist_t;

  typedef struct packed {
    hist_t idx;
    logic  lp;
    logic  gp;
    logic  final_pred;
  } tp_entry_t;

endpackage

// File: rtl/tournament_entry_fifo.sv
// Circular buffer of in-flight predictions.
// Flush beats push and pop; the occupancy count is registered.
module tournament_entry_fifo
  import tournament_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  tp_entry_t        wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output tp_entry_t        rdata_o,
  output logic [CNT_W-1:0] count_o
);

  tp_entry_t        mem_q [DEPTH];
  tp_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q < CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

  // Next pointers, count and storage; flush empties the queue.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = wdata_i;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers; reset drops every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tournament_history_tracker.sv
// Speculative GHR owner and choice-table trainer.
// Pushes predictions in order, trains at resolve, repairs GHR.
module tournament_history_tracker
  import tournament_pkg::*;
#(
  parameter int HIST_W = TP_HIST_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid_i,
  output logic                     pred_ready_o,
  input  logic                     lp_pred_i,
  input  logic                     gp_pred_i,
  input  logic                     choice_i,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  output logic [HIST_W-1:0]        global_history_o,
  output logic                     upd_valid_o,
  output logic [HIST_W-1:0]        upd_idx_o,
  output logic                     upd_inc_o,
  output logic                     upd_dec_o,
  output logic                     mispredict_o,
  output logic                     resolve_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              uv_q, uv_d;
  logic [HIST_W-1:0] uidx_q, uidx_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  tp_entry_t         head;
  tp_entry_t         wdata;
  logic [CNT_W-1:0]  count;
  logic              final_pred;
  logic              res_hit;
  logic              miss;
  logic              push_ok;

  assign final_pred = choice_i ? gp_pred_i : lp_pred_i;
  assign pred_ready_o = count < CNT_W'(DEPTH);
  assign res_hit = resolve_valid_i && (count != '0);
  assign miss = res_hit && (head.final_pred != resolve_taken_i);
  assign push_ok = pred_valid_i && pred_ready_o && !miss;

  assign wdata.idx        = ghr_q;
  assign wdata.lp         = lp_pred_i;
  assign wdata.gp         = gp_pred_i;
  assign wdata.final_pred = final_pred;

  tournament_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_ok),
    .wdata_i (wdata),
    .pop_i   (res_hit),
    .flush_i (miss),
    .rdata_o (head),
    .count_o (count)
  );

  // GHR update: repair on mispredict, else shift in new final.
  always_comb begin
    ghr_d = ghr_q;
    if (miss) begin
      ghr_d = {head.idx[HIST_W-2:0], resolve_taken_i};
    end else if (push_ok) begin
      ghr_d = {ghr_q[HIST_W-2:0], final_pred};
    end
  end

  // Training command and error pulse for the next cycle.
  always_comb begin
    uv_d   = res_hit;
    uidx_d = res_hit ? head.idx : '0;
    inc_d  = res_hit && (head.gp == resolve_taken_i)
                     && (head.lp != resolve_taken_i);
    dec_d  = res_hit && (head.lp == resolve_taken_i)
                     && (head.gp != resolve_taken_i);
    mis_d  = miss;
    err_d  = resolve_valid_i && (count == '0);
  end

  // Registers; reset clears history and any pending command.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_q  <= '0;
      uv_q   <= 1'b0;
      uidx_q <= '0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ghr_q  <= ghr_d;
      uv_q   <= uv_d;
      uidx_q <= uidx_d;
      inc_q  <= inc_d;
      dec_q  <= dec_d;
      mis_q  <= mis_d;
      err_q  <= err_d;
    end
  end

  assign global_history_o = ghr_q;
  assign upd_valid_o      = uv_q;
  assign upd_idx_o        = uidx_q;
  assign upd_inc_o        = inc_q;
  assign upd_dec_o        = dec_q;
  assign mispredict_o     = mis_q;
  assign resolve_err_o    = err_q;
  assign count_o          = count;

endmodule

// File: tb/tb_tournament_history_tracker.sv
// Bench for tournament_history_tracker: fixed vectors,
// hand sequences and random traffic against a queue model.
module tb_tournament_history_tracker;

  localparam int HW = 12;
  localparam int DP = 8;
  localparam int MASK = (1 << HW) - 1;

  logic          clock = 0;
  logic          reset;
  logic          pred_valid_i, lp_pred_i, gp_pred_i, choice_i;
  logic          resolve_valid_i, resolve_taken_i;
  logic          pred_ready_o;
  logic [HW-1:0] global_history_o, upd_idx_o;
  logic          upd_valid_o, upd_inc_o, upd_dec_o;
  logic          mispredict_o, resolve_err_o;
  logic [3:0]    count_o;

  always #5 clock = ~clock;

  tournament_history_tracker #(.HIST_W(HW), .DEPTH(DP)) dut (
    .clock            (clock),
    .reset            (reset),
    .pred_valid_i     (pred_valid_i),
    .pred_ready_o     (pred_ready_o),
    .lp_pred_i        (lp_pred_i),
    .gp_pred_i        (gp_pred_i),
    .choice_i         (choice_i),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_taken_i  (resolve_taken_i),
    .global_history_o (global_history_o),
    .upd_valid_o      (upd_valid_o),
    .upd_idx_o        (upd_idx_o),
    .upd_inc_o        (upd_inc_o),
    .upd_dec_o        (upd_dec_o),
    .mispredict_o     (mispredict_o),
    .resolve_err_o    (resolve_err_o),
    .count_o          (count_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    bit lp, gp, fin;
  } m_ent_t;

  m_ent_t q[$];
  int     m_ghr;
  bit     e_uv, e_inc, e_dec, e_mis, e_err;
  int     e_idx;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour, evaluated on the pre-edge state.
  task automatic model(input bit rst, input bit pv, input bit lp,
                       input bit gp, input bit ch, input bit rv,
                       input bit rt);
    bit fin, rdy, miss;
    m_ent_t h, n;
    e_uv = 0; e_inc = 0; e_dec = 0; e_mis = 0; e_err = 0; e_idx = 0;
    if (rst) begin
      q.delete();
      m_ghr = 0;
      return;
    end
    fin  = ch ? gp : lp;
    rdy  = q.size() < DP;
    miss = 0;
    if (rv && q.size() == 0) e_err = 1;
    if (rv && q.size() > 0) begin
      h = q[0];
      e_uv  = 1;
      e_idx = h.idx;
      e_inc = (h.gp == rt) && (h.lp != rt);
      e_dec = (h.lp == rt) && (h.gp != rt);
      miss  = (h.fin != rt);
      e_mis = miss;
      if (miss) begin
        q.delete();
        m_ghr = ((h.idx << 1) | int'(rt)) & MASK;
      end else begin
        void'(q.pop_front());
      end
    end
    if (pv && rdy && !miss) begin
      n.idx = m_ghr; n.lp = lp; n.gp = gp; n.fin = fin;
      q.push_back(n);
      m_ghr = ((m_ghr << 1) | int'(fin)) & MASK;
    end
  endtask

  task automatic compare_all();
    chk("ghr", int'(global_history_o), m_ghr);
    chk("count", int'(count_o), q.size());
    chk("ready", int'(pred_ready_o), int'(q.size() < DP));
    chk("upd_valid", int'(upd_valid_o), int'(e_uv));
    chk("upd_idx", int'(upd_idx_o), e_idx);
    chk("upd_inc", int'(upd_inc_o), int'(e_inc));
    chk("upd_dec", int'(upd_dec_o), int'(e_dec));
    chk("mispredict", int'(mispredict_o), int'(e_mis));
    chk("resolve_err", int'(resolve_err_o), int'(e_err));
  endtask

  task automatic step(input bit rst, input bit pv, input bit lp,
                      input bit gp, input bit ch, input bit rv,
                      input bit rt);
    reset = rst; pred_valid_i = pv; lp_pred_i = lp;
    gp_pred_i = gp; choice_i = ch;
    resolve_valid_i = rv; resolve_taken_i = rt;
    model(rst, pv, lp, gp, ch, rv, rt);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit pv, lp, gp, ch, rv, rt;
    int ghr, cnt, idx;
    bit uv, inc, mis, err;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1,0,1,1, 0,0, 'h001, 1, 0, 0,0,0,0};
    vt[1] = '{1,0,1,0, 0,0, 'h002, 2, 0, 0,0,0,0};
    vt[2] = '{1,0,1,1, 0,0, 'h005, 3, 0, 0,0,0,0};
    vt[3] = '{0,0,0,0, 1,1, 'h005, 2, 0, 1,1,0,0};
    vt[4] = '{1,1,1,1, 1,1, 'h003, 0, 1, 1,1,1,0};
    vt[5] = '{0,0,0,0, 1,0, 'h003, 0, 0, 0,0,0,1};
    vt[6] = '{0,0,0,0, 0,0, 'h003, 0, 0, 0,0,0,0};

    step(1, 0,0,0,0, 0,0);
    step(1, 0,0,0,0, 0,0);
    chk("rst_ready", int'(pred_ready_o), 1);
    chk("rst_count", int'(count_o), 0);

    for (int i = 0; i < 7; i++) begin
      step(0, vt[i].pv, vt[i].lp, vt[i].gp, vt[i].ch,
           vt[i].rv, vt[i].rt);
      chk($sformatf("vec%0d_ghr", i), int'(global_history_o), vt[i].ghr);
      chk($sformatf("vec%0d_cnt", i), int'(count_o), vt[i].cnt);
      chk($sformatf("vec%0d_idx", i), int'(upd_idx_o), vt[i].idx);
      chk($sformatf("vec%0d_uv", i), int'(upd_valid_o), int'(vt[i].uv));
      chk($sformatf("vec%0d_inc", i), int'(upd_inc_o), int'(vt[i].inc));
      chk($sformatf("vec%0d_mis", i), int'(mispredict_o), int'(vt[i].mis));
      chk($sformatf("vec%0d_err", i), int'(resolve_err_o), int'(vt[i].err));
    end

    // Fill to full, then push + correct resolve at full.
    for (int i = 0; i < 8; i++) step(0, 1,1,1,1, 0,0);
    chk("full_ready", int'(pred_ready_o), 0);
    chk("full_count", int'(count_o), 8);
    step(0, 1,1,1,1, 1,1);
    chk("full_pop_count", int'(count_o), 7);
    chk("full_pop_uv", int'(upd_valid_o), 1);
    chk("full_pop_mis", int'(mispredict_o), 0);

    // Reset with 5 queued and a resolve pending.
    step(0, 0,0,0,0, 1,1);
    step(0, 0,0,0,0, 1,1);
    chk("pre_rst_count", int'(count_o), 5);
    step(1, 1,1,1,1, 1,1);
    chk("mid_rst_count", int'(count_o), 0);
    chk("mid_rst_ghr", int'(global_history_o), 0);
    chk("mid_rst_uv", int'(upd_valid_o), 0);
    chk("mid_rst_ready", int'(pred_ready_o), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, pv, lp, gp, ch, rv, rt;
      r  = ($urandom_range(0, 199) == 0);
      pv = ($urandom_range(0, 9) < 7);
      lp = $urandom_range(0, 1);
      gp = $urandom_range(0, 1);
      ch = $urandom_range(0, 1);
      rv = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) rt = q[0].fin;
      else rt = $urandom_range(0, 1);
      step(r, pv, lp, gp, ch, rv, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tournament_history_tracker.md
Name: tournament_history_tracker

Overview:
- Trainer/writer side of the tournament choice predictor.
- Owns the speculative global history register (GHR) that indexes the choice table, and records each issued prediction in an in-order queue.
- At branch resolution, pops the oldest entry, produces the choice-table training command (index, increment/decrement), and repairs the GHR on a mispredict.
- Sits between fetch/predict (push side) and branch resolution (pop side).

Parameters:
- HIST_W, 12, GHR width; also the width of the choice-table index.
- DEPTH, 8, maximum in-flight predictions; power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- pred_valid_i  in  1  new prediction issued this cycle.
- pred_ready_o  out  1  queue can accept a prediction.
- lp_pred_i  in  1  local predictor direction.
- gp_pred_i  in  1  global predictor direction.
- choice_i  in  1  choice predictor output; 1 selects global.
- resolve_valid_i  in  1  oldest branch resolves this cycle.
- resolve_taken_i  in  1  actual direction.
- global_history_o  out  HIST_W  current speculative GHR; feeds the choice-table index.
- upd_valid_o  out  1  training command valid.
- upd_idx_o  out  HIST_W  choice-table index to train.
- upd_inc_o  out  1  count toward global.
- upd_dec_o  out  1  count toward local.
- mispredict_o  out  1  final prediction was wrong; one-cycle pulse.
- resolve_err_o  out  1  resolve arrived while the queue was empty; one-cycle pulse.
- count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset:
  - GHR = 0 and queue empty.
  - All outputs 0, except pred_ready_o = 1.
  - Reset mid-operation discards all entries next edge; no training command is emitted.
- Final prediction: final = choice_i ? gp_pred_i : lp_pred_i.
- Push (pred_valid_i && pred_ready_o):
  - Write entry {idx = GHR before update, lp, gp, final} at the tail.
  - GHR <= {GHR[HIST_W-2:0], final}.
- pred_ready_o = (count < DEPTH):
  - Decoded from registered count only; no combinational path from the resolve inputs.
  - A resolve in the same cycle does not raise ready when the queue is full.
- Resolve, queue non-empty (head entry E), outputs registered (1-cycle latency):
  - upd_valid_o = 1 and upd_idx_o = E.idx.
  - upd_inc_o = (E.gp == taken) && (E.lp != taken).
  - upd_dec_o = (E.lp == taken) && (E.gp != taken).
  - If both predictors were right or both wrong: upd_valid_o = 1 with inc = dec = 0. The choice table ignores it.
  - inc and dec are never both 1.
  - mispredict_o = (E.final != taken).
- Mispredict repair, same edge as the pop:
  - GHR <= {E.idx[HIST_W-2:0], taken}.
  - Queue flushed: count = 0 and head = tail.
  - A push in the same cycle is dropped and does not affect the GHR.
- Correct resolve: pop the head only. A simultaneous push also completes, so count is unchanged and the GHR shifts in the new final.
- Resolve when empty: no pop and no training. resolve_err_o = 1 next cycle. A simultaneous push proceeds normally.
- Pointers:
  - $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count saturates at no value: a push at full is impossible by ready.
- upd_*, mispredict_o and resolve_err_o are 0 in every cycle that does not follow a resolve.

Decomposition:
- tournament_pkg:
  - HIST_W default constant.
  - typedef hist_t.
  - typedef struct packed tp_entry_t {hist_t idx; logic lp; logic gp; logic final_pred;}.
  - Shared with the choice predictor and the global predictor.
- Sub-module tournament_entry_fifo:
  - Circular buffer of tp_entry_t with push, pop, flush and count.
  - Flush has priority over push.
- The top level holds the GHR, training logic and output registers.

Test Plan:
- Reset, then 3 pushes with final = 1,0,1 from GHR = 0 -> GHR = 12'h005, count_o = 3; entry idx values are 0x000, 0x001, 0x002.
- Head lp = 0, gp = 1, choice = 1; resolve taken = 1 -> next cycle upd_valid_o = 1, upd_idx_o = 0x000, upd_inc_o = 1, mispredict_o = 0; count = 2.
- Head idx = 0x001, final = 0, lp = 0, gp = 1; resolve taken = 1 with a simultaneous push -> upd_inc_o = 1, mispredict_o = 1, GHR = 0x003, count = 0, push dropped.
- 8 pushes -> pred_ready_o = 0. A 9th push plus a correct resolve in the same cycle -> the push is not accepted and count = 7 next cycle.
- Resolve on an empty queue -> resolve_err_o = 1 for one cycle; upd_valid_o = 0; GHR unchanged.
- Assert reset with 5 entries queued and a resolve pending -> next cycle count = 0, GHR = 0, upd_valid_o = 0, pred_ready_o = 1.
